// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core register file: default widths,
// the hard-wired zero register index, and per-port bus slicing.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural index of the hard-wired zero register.
  localparam int REG_ZERO = 0;

  // LSB of port k's field within a flattened multi-port bus of w-bit fields.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. Decode sets a register's bit when it issues
// a producer, writeback clears it, and a pipeline flush clears everything.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    wa0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    wa1,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_next;

  // Next busy vector: flush beats a new issue, and a new issue beats a completing write.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (flush) begin
        busy_next[r] = 1'b0;
      end else if (issue_en && (issue_addr == ADDR_W'(r))) begin
        busy_next[r] = 1'b1;
      end else if ((we0 && (wa0 == ADDR_W'(r))) || (we1 && (wa1 == ADDR_W'(r)))) begin
        busy_next[r] = 1'b0;
      end else begin
        busy_next[r] = busy[r];
      end
    end
    if (ZERO_REG != 0) begin
      busy_next[REG_ZERO] = 1'b0;
    end else begin
      busy_next[REG_ZERO] = busy_next[REG_ZERO];
    end
  end

  // Busy state register; reset leaves no outstanding producers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Summary of the registered vector only; same-cycle writebacks are not considered.
  assign busy_any = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined MIPS core: NREAD combinational
// read ports with write-through bypass, two writeback ports (WB1 beats WB0 on
// an address collision), and a busy scoreboard for RAW stall detection.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic                    flush,
  output logic                    busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wen0;
  logic              wen1;

  // Writes to the hard-wired zero register are discarded before they reach the array.
  assign wen0 = we0 && !(ZR && (wa0 == ZADDR));
  assign wen1 = we1 && !(ZR && (wa1 == ZADDR));

  // Register array update; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wen0) begin
        rf[wa0] <= wd0;
      end
      if (wen1) begin
        rf[wa1] <= wd1;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .we0        (we0),
    .wa0        (wa0),
    .we1        (we1),
    .wa1        (wa1),
    .flush      (flush),
    .busy       (busy),
    .busy_any   (busy_any)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
    // Forwarding needs the enable: an idle write port never matches on address alone.
    assign hit1 = BP && we1 && (wa1 == addr);
    assign hit0 = BP && we0 && (wa0 == addr);

    // Read mux: zero register, then WB1 forward, then WB0 forward, then the array.
    always_comb begin
      data = rf[addr];
      if (ZR && (addr == ZADDR)) begin
        data = '0;
      end else if (hit1) begin
        data = wd1;
      end else if (hit0) begin
        data = wd0;
      end else begin
        data = rf[addr];
      end
    end

    assign rd_data[port_lsb(k, DATA_W) +: DATA_W] = data;
    // A value being forwarded this cycle satisfies the consumer, so it is not a stall.
    assign rd_busy[k] = busy[addr] & ~(hit0 | hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a default instance (2 ports, bypass on)
// and a 3-port no-bypass instance share the write/issue stimulus. Expected
// values are queued when stimulus is driven and popped at the falling edge.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [14:0] rd_addr3 = '0;
  logic [63:0] rd_data;
  logic [95:0] rd_data3;
  logic [1:0]  rd_busy;
  logic [2:0]  rd_busy3;
  logic        we0 = 1'b0, we1 = 1'b0, issue_en = 1'b0, flush = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, issue_addr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        busy_any, busy_any3;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_any(busy_any)
  );

  regfile_mp #(.NREAD(3), .BYPASS(0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_busy(rd_busy3),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_any(busy_any3)
  );

  // Observed value selector: 0-1 data A, 2-3 busy A, 4 busy_any A, 5-7 data B, 8-10 busy B.
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return rd_data[31:0];
      1: return rd_data[63:32];
      2: return {31'd0, rd_busy[0]};
      3: return {31'd0, rd_busy[1]};
      4: return {31'd0, busy_any};
      5: return rd_data3[31:0];
      6: return rd_data3[63:32];
      7: return rd_data3[95:64];
      8: return {31'd0, rd_busy3[0]};
      9: return {31'd0, rd_busy3[1]};
      10: return {31'd0, rd_busy3[2]};
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_val(e.tag, obs(e.sel), e.val);
    end
  endtask

  // Compare at the falling edge, then let the rising edge commit the stimulus.
  task automatic cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_rd3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr3 = {a2, a1, a0};
  endtask

  initial begin
    // Power-on reset state.
    set_rd(5'd3, 5'd5);
    #2;
    expect_val("rst_data", 0, 32'h0);
    expect_val("rst_busy", 3, 32'h0);
    expect_val("rst_any", 4, 32'h0);
    drain();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Write r5 and issue r6.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    issue_en = 1'b1; issue_addr = 5'd6;
    set_rd(5'd5, 5'd6);
    expect_val("wr_bypass_r5", 0, 32'hDEAD_BEEF);
    cycle();
    idle();
    expect_val("stored_r5", 0, 32'hDEAD_BEEF);
    expect_val("busy_r6", 3, 32'h1);
    expect_val("any_r6", 4, 32'h1);
    cycle();

    // Asynchronous reset mid-cycle.
    #2;
    reset_n = 1'b0;
    #1;
    set_rd(5'd5, 5'd6);
    expect_val("arst_r5", 0, 32'h0);
    expect_val("arst_busy", 3, 32'h0);
    expect_val("arst_any", 4, 32'h0);
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Dual write to the same address: port 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    set_rd(5'd7, 5'd5);
    set_rd3(5'd7, 5'd0, 5'd0);
    expect_val("dual_bypass", 0, 32'h22);
    expect_val("post_rst_r5", 1, 32'h0);
    expect_val("dual_nobyp_old", 5, 32'h0);
    cycle();
    idle();
    expect_val("dual_stored", 0, 32'h22);
    expect_val("dual_stored_b", 5, 32'h22);
    cycle();

    // Zero register ignores writes and issues.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    set_rd(5'd0, 5'd7);
    expect_val("zero_bypass", 0, 32'h0);
    expect_val("zero_busy_now", 2, 32'h0);
    cycle();
    idle();
    set_rd3(5'd7, 5'd0, 5'd0);
    expect_val("zero_read", 0, 32'h0);
    expect_val("zero_busy", 2, 32'h0);
    expect_val("zero_any", 4, 32'h0);
    expect_val("zero_read_b", 6, 32'h0);
    cycle();

    // Scoreboard set by issue, cleared by writeback.
    issue_en = 1'b1; issue_addr = 5'd9;
    set_rd(5'd9, 5'd0);
    set_rd3(5'd9, 5'd0, 5'd0);
    expect_val("issue_busy_now", 2, 32'h0);
    cycle();
    idle();
    expect_val("issue_busy", 2, 32'h1);
    expect_val("issue_any", 4, 32'h1);
    cycle();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55;
    expect_val("wb_busy_masked", 2, 32'h0);
    expect_val("wb_bypass", 0, 32'h55);
    expect_val("wb_any_still", 4, 32'h1);
    expect_val("wb_nobyp_busy", 8, 32'h1);
    expect_val("wb_nobyp_data", 5, 32'h0);
    cycle();
    idle();
    expect_val("wb_any_clear", 4, 32'h0);
    expect_val("wb_stored", 0, 32'h55);
    cycle();

    // Set beats a same-cycle clear.
    issue_en = 1'b1; issue_addr = 5'd3;
    cycle();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
    set_rd(5'd3, 5'd4);
    expect_val("coll_busy_masked", 2, 32'h0);
    cycle();
    idle();
    expect_val("coll_busy", 2, 32'h1);
    expect_val("coll_data", 0, 32'h33);
    expect_val("coll_any", 4, 32'h1);
    cycle();

    // Flush drops everything, including a same-cycle issue.
    flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd4;
    expect_val("flush_busy4_now", 3, 32'h0);
    cycle();
    idle();
    expect_val("flush_busy3", 2, 32'h0);
    expect_val("flush_busy4", 3, 32'h0);
    expect_val("flush_any", 4, 32'h0);
    cycle();

    // Three ports, no bypass: old data and unmasked busy during the write.
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h10;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h20;
    cycle();
    idle();
    issue_en = 1'b1; issue_addr = 5'd1;
    cycle();
    idle();
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hAB;
    set_rd(5'd1, 5'd2);
    set_rd3(5'd1, 5'd2, 5'd1);
    expect_val("np_p0_old", 5, 32'h10);
    expect_val("np_p1", 6, 32'h20);
    expect_val("np_p2_old", 7, 32'h10);
    expect_val("np_busy_p0", 8, 32'h1);
    expect_val("np_busy_p1", 9, 32'h0);
    expect_val("np_busy_p2", 10, 32'h1);
    expect_val("byp_p0_new", 0, 32'hAB);
    expect_val("byp_busy_masked", 2, 32'h0);
    cycle();
    idle();
    expect_val("np_p0_new", 5, 32'hAB);
    expect_val("np_p2_new", 7, 32'hAB);
    expect_val("np_busy_clear", 8, 32'h0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
